// File: rtl/wb_stage.sv
// Writeback stage: registers ALU results or aligned load data into the register file.
// Optional same-cycle forwarding of the write port is enabled with `define WB_FORWARD_EN.
module wb_stage #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_dest,
  input  logic [DATA_WIDTH-1:0] in_result,
  input  logic                  in_is_load,
  input  logic [2:0]            in_ld_type,
  input  logic [1:0]            in_addr_lo,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic [ADDR_WIDTH-1:0] busy_dest,
  output logic                  misalign,
  input  logic [ADDR_WIDTH-1:0] fwd_raddr1,
  input  logic [ADDR_WIDTH-1:0] fwd_raddr2,
  output logic                  fwd_hit1,
  output logic                  fwd_hit2,
  output logic [DATA_WIDTH-1:0] fwd_data1,
  output logic [DATA_WIDTH-1:0] fwd_data2
);

  typedef enum logic [1:0] {IDLE, WAIT_MEM, WRITE} state_t;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  state_t                state, state_d;
  logic [ADDR_WIDTH-1:0] ld_dest, ld_dest_d;
  logic [2:0]            ld_type, ld_type_d;
  logic [1:0]            ld_lo, ld_lo_d;
  logic                  wen_d, mis_d;
  logic [ADDR_WIDTH-1:0] waddr_d, busy_d;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic                  accept;

  // Extract and extend the addressed byte/half from the memory word.
  function automatic logic [DATA_WIDTH-1:0] align(input logic [DATA_WIDTH-1:0] w,
                                                  input logic [2:0] t,
                                                  input logic [1:0] lo);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {lo, 3'b000});
    h = 16'(w >> {lo[1], 4'b0000});
    case (t)
      LD_LB:   return {{(DATA_WIDTH-8){b[7]}}, b};
      LD_LH:   return {{(DATA_WIDTH-16){h[15]}}, h};
      LD_LBU:  return {{(DATA_WIDTH-8){1'b0}}, b};
      LD_LHU:  return {{(DATA_WIDTH-16){1'b0}}, h};
      default: return w;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] t, input logic [1:0] lo);
    return (((t == LD_LH) || (t == LD_LHU)) && lo[0]) || ((t == LD_LW) && (lo != 2'b00));
  endfunction

  assign in_ready = rst && (state != WAIT_MEM);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE, WRITE: begin
        if (accept) state_d = in_is_load ? WAIT_MEM : WRITE;
        else        state_d = IDLE;
      end
      WAIT_MEM: if (mem_rvalid) state_d = WRITE;
      default:  state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and the pending-load context.
  always_comb begin
    wen_d     = 1'b0;
    mis_d     = 1'b0;
    busy_d    = '0;
    waddr_d   = rf_waddr;
    wdata_d   = rf_wdata;
    ld_dest_d = ld_dest;
    ld_type_d = ld_type;
    ld_lo_d   = ld_lo;
    if (state == WAIT_MEM) begin
      if (mem_rvalid) begin
        if (misaligned(ld_type, ld_lo)) begin
          mis_d = 1'b1;
        end else if (ld_dest != '0) begin
          wen_d   = 1'b1;
          waddr_d = ld_dest;
          wdata_d = align(mem_rdata, ld_type, ld_lo);
        end
      end else begin
        busy_d = ld_dest;
      end
    end else if (accept) begin
      if (in_is_load) begin
        ld_dest_d = in_dest;
        ld_type_d = in_ld_type;
        ld_lo_d   = in_addr_lo;
        busy_d    = in_dest;
      end else if (in_dest != '0) begin
        wen_d   = 1'b1;
        waddr_d = in_dest;
        wdata_d = in_result;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rf_wen    <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      busy_dest <= '0;
      misalign  <= 1'b0;
      ld_dest   <= '0;
      ld_type   <= 3'b000;
      ld_lo     <= 2'b00;
    end else begin
      rf_wen    <= wen_d;
      rf_waddr  <= waddr_d;
      rf_wdata  <= wdata_d;
      busy_dest <= busy_d;
      misalign  <= mis_d;
      ld_dest   <= ld_dest_d;
      ld_type   <= ld_type_d;
      ld_lo     <= ld_lo_d;
    end
  end

`ifdef WB_FORWARD_EN
  assign fwd_hit1  = rf_wen && (fwd_raddr1 == rf_waddr);
  assign fwd_hit2  = rf_wen && (fwd_raddr2 == rf_waddr);
  assign fwd_data1 = fwd_hit1 ? rf_wdata : '0;
  assign fwd_data2 = fwd_hit2 ? rf_wdata : '0;
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_raddr1, fwd_raddr2};
  assign fwd_hit1   = 1'b0;
  assign fwd_hit2   = 1'b0;
  assign fwd_data1  = '0;
  assign fwd_data2  = '0;
`endif

endmodule
